// File: rtl/intt_seq.sv
// intt_seq: area-oriented inverse NTT using a single multiply-accumulate datapath, O(N^2) cycles.
// Optional macro INTT_SCALE_EN: when defined, SCALE multiplies by n_inv; otherwise res = acc.
module intt_seq #(
  parameter int N  = 128,
  parameter int CW = 4,
  parameter int QW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [QW-1:0]        q,
  input  logic [QW-1:0]        w_inv,
  input  logic [QW-1:0]        n_inv,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [QW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_index,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int IW = $clog2(N);
  localparam int PW = 2 * QW + 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_SCALE, S_EMIT} state_t;

  state_t          state, state_nx;
  logic [QW-1:0]   q_r, w_r;
  logic [IW-1:0]   i_cnt, j_cnt;
  logic [QW-1:0]   t, p, acc, res;
  logic [QW-1:0]   mem [N];
  logic            in_hs, out_hs, i_last, j_last, q_ok;
  logic [PW-1:0]   q_ext, mac_sum;
  logic [QW-1:0]   ld_val, acc_nx, p_nx, t_nx, res_nx, w_mod;

  assign in_hs  = (state == S_LOAD) && in_valid;
  assign out_hs = (state == S_EMIT) && out_ready;
  assign i_last = (i_cnt == IW'(N - 1));
  assign j_last = (j_cnt == IW'(N - 1));
  assign q_ok   = (q >= QW'(2));

  // Outputs come from state or registers only, never straight from inputs.
  assign in_ready  = (state == S_LOAD);
  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE);
  assign out_data  = res;
  assign out_index = j_cnt;

  // Every product is 2*QW bits and reduced mod q in the same cycle.
  assign q_ext   = PW'(q_r);
  assign mac_sum = PW'(mem[i_cnt]) * PW'(p) + PW'(acc);
  assign acc_nx  = QW'(mac_sum % q_ext);
  assign p_nx    = QW'((PW'(p) * PW'(t)) % q_ext);
  assign t_nx    = QW'((PW'(t) * PW'(w_r)) % q_ext);
  assign ld_val  = QW'(PW'(in_data) % q_ext);
  assign w_mod   = w_inv % q;

`ifdef INTT_SCALE_EN
  logic [QW-1:0] ninv_r;
  assign res_nx = QW'((PW'(acc) * PW'(ninv_r)) % q_ext);
`else
  // n_inv has no function without scaling; reduce it so it is visibly consumed.
  logic unused_ninv;
  assign unused_ninv = ^n_inv;
  assign res_nx      = acc;
`endif

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start && q_ok)   state_nx = S_LOAD;
      S_LOAD:  if (in_hs && i_last) state_nx = S_MAC;
      S_MAC:   if (i_last)          state_nx = S_SCALE;
      S_SCALE:                      state_nx = S_EMIT;
      S_EMIT:  if (out_hs)          state_nx = j_last ? S_IDLE : S_MAC;
      default:                      state_nx = S_IDLE;
    endcase
  end

  // NOTE: the coefficient buffer is not reset; LOAD overwrites every entry before MAC reads it.
  always_ff @(posedge clk) begin
    if (in_hs) mem[i_cnt] <= ld_val;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r   <= '0;
      w_r   <= '0;
      i_cnt <= '0;
      j_cnt <= '0;
      t     <= '0;
      p     <= '0;
      acc   <= '0;
      res   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef INTT_SCALE_EN
      ninv_r <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && q_ok) begin
            q_r   <= q;
            w_r   <= w_mod;
            i_cnt <= '0;
            j_cnt <= '0;
            t     <= '0;
            p     <= '0;
            acc   <= '0;
`ifdef INTT_SCALE_EN
            ninv_r <= n_inv % q;
`endif
          end else if (start) begin
            err <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_hs) begin
            i_cnt <= i_cnt + 1'b1;
            if (i_last) begin
              j_cnt <= '0;
              t     <= QW'(1);
              p     <= QW'(1);
              acc   <= '0;
            end
          end
        end
        S_MAC: begin
          acc   <= acc_nx;
          p     <= p_nx;
          i_cnt <= i_cnt + 1'b1;
        end
        S_SCALE: begin
          res <= res_nx;
          t   <= t_nx;  // advances t to w_inv^(j+1) for the next output
        end
        S_EMIT: begin
          if (out_hs && !j_last) begin
            j_cnt <= j_cnt + 1'b1;
            acc   <= '0;
            p     <= QW'(1);
          end
          if (out_hs && j_last) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_intt_seq.sv
// Self-checking bench for intt_seq (N=4): fixed vectors, random vectors against a direct-formula model,
// plus hand sequences for back-pressure, rejected start, ignored start and mid-transform reset.
module tb_intt_seq;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int QW = 8;

  logic          clk = 1'b0;
  logic          rst, start, in_valid, out_ready;
  logic [QW-1:0] q, w_inv, n_inv;
  logic [CW-1:0] in_data;
  logic          in_ready, out_valid, busy, done, err;
  logic [QW-1:0] out_data;
  logic [1:0]    out_index;

  intt_seq #(.N(N), .CW(CW), .QW(QW)) dut (
    .clk(clk), .rst(rst), .start(start), .q(q), .w_inv(w_inv), .n_inv(n_inv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [QW-1:0]             q;
    logic [QW-1:0]             w;
    logic [QW-1:0]             ni;
    logic [N-1:0][CW-1:0]      x;
    logic [N-1:0][QW-1:0]      e;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  // a[j] = n_inv * sum_i X[i] * w_inv^(i*j) mod q, evaluated term by term from the definition.
  function automatic logic [N-1:0][QW-1:0] ref_intt(input vec_t v);
    logic [N-1:0][QW-1:0] r;
    longint unsigned m, w, s, pw;
    m = v.q;
    w = v.w % m;
    for (int j = 0; j < N; j++) begin
      s = 0;
      for (int i = 0; i < N; i++) begin
        pw = 1;
        for (int k = 0; k < i * j; k++) pw = (pw * w) % m;
        s = (s + (v.x[i] % m) * pw) % m;
      end
`ifdef INTT_SCALE_EN
      s = (s * (v.ni % m)) % m;
`endif
      r[j] = QW'(s);
    end
    return r;
  endfunction

  task automatic start_xfer(input vec_t v);
    start = 1'b1; q = v.q; w_inv = v.w; n_inv = v.ni;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 0, busy, 1);
  endtask

  task automatic load(input logic [N-1:0][CW-1:0] x, output int l);
    int n;
    l = 0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = x[i];
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      check("load_ready", i, in_ready, 1);
      l = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic emit(input logic [N-1:0][QW-1:0] e, input int l0, input int stall_j, input int stop_j);
    int l, n;
    l = l0;
    for (int j = 0; j < N; j++) begin
      if (j == stop_j) return;
      n = 0;
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      check("out_latency", j, cyc - l, N + 2);
      check("out_data", j, out_data, e[j]);
      check("out_index", j, out_index, j);
      if (j == stall_j) begin
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_valid", j, out_valid, 1);
          check("stall_data", j, out_data, e[j]);
          check("stall_index", j, out_index, j);
        end
        out_ready = 1'b1;
      end
      l = cyc;
      @(negedge clk);
      if (j < N - 1) begin
        check("valid_drop", j, out_valid, 0);
      end else begin
        check("done_pulse", j, done, 1);
        check("busy_fall", j, busy, 0);
        @(negedge clk);
        check("done_clear", j, done, 0);
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input int stall_j, input int stop_j);
    int l;
    start_xfer(v);
    load(v.x, l);
    emit(v.e, l, stall_j, stop_j);
  endtask

  task automatic check_reset_outputs(input int idx);
    check("rst_in_ready", idx, in_ready, 0);
    check("rst_out_valid", idx, out_valid, 0);
    check("rst_busy", idx, busy, 0);
    check("rst_done", idx, done, 0);
    check("rst_err", idx, err, 0);
    check("rst_out_data", idx, out_data, 0);
    check("rst_out_index", idx, out_index, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int l;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    q = '0; w_inv = '0; n_inv = '0;

    // Fixed vectors with hand-derived results, then random vectors scored by the model.
    tbl[0].q = 8'd17; tbl[0].w = 8'd13; tbl[0].ni = 8'd13;
    tbl[0].x = {4'd6, 4'd15, 4'd7, 4'd10};                 // X[3..0]
`ifdef INTT_SCALE_EN
    tbl[0].e = {8'd4, 8'd3, 8'd2, 8'd1};                   // a[3..0]
`else
    tbl[0].e = {8'd16, 8'd12, 8'd8, 8'd4};
`endif
    tbl[1].q = 8'd17; tbl[1].w = 8'd13; tbl[1].ni = 8'd13;
    tbl[1].x = '0;
    tbl[1].e = '0;
    tbl[2].q = 8'd17; tbl[2].w = 8'd13; tbl[2].ni = 8'd13;
    tbl[2].x = {4'd0, 4'd0, 4'd0, 4'd1};
`ifdef INTT_SCALE_EN
    tbl[2].e = {8'd13, 8'd13, 8'd13, 8'd13};
`else
    tbl[2].e = {8'd1, 8'd1, 8'd1, 8'd1};
`endif
    for (int k = 3; k < 8; k++) begin
      tbl[k].q  = QW'($urandom_range(2, 255));
      tbl[k].w  = QW'($urandom);
      tbl[k].ni = QW'($urandom);
      for (int i = 0; i < N; i++) tbl[k].x[i] = CW'($urandom);
      tbl[k].e = ref_intt(tbl[k]);
    end

    repeat (2) @(negedge clk);
    check_reset_outputs(0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      run_vec(tbl[k], (k == 0) ? 1 : -1, -1);
      @(negedge clk);
    end

    // Rejected start: q below 2 gives a single err pulse and no activity.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; q = QW'(k);
      @(negedge clk);
      start = 1'b0;
      check("err_pulse", k, err, 1);
      check("err_busy", k, busy, 0);
      check("err_in_ready", k, in_ready, 0);
      @(negedge clk);
      check("err_clear", k, err, 0);
      check("err_idle", k, busy, 0);
    end

    // A start while busy is ignored without err and the transform still completes correctly.
    start_xfer(tbl[0]);
    start = 1'b1; q = 8'd1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_no_err", 0, err, 0);
    check("busy_start_loading", 0, in_ready, 1);
    load(tbl[0].x, l);
    emit(tbl[0].e, l, -1, -1);
    @(negedge clk);

    // Reset while computing j=2 discards the transform; the next one is still correct.
    run_vec(tbl[0], -1, 2);
    check("pre_rst_busy", 0, busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs(2);
    run_vec(tbl[3], -1, -1);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
